// File: rtl/prog_freq_divider.sv
// Programmable clock divider: divides clk by a runtime-loadable N (2..2^WIDTH-1).
// Outputs a one-cycle tick at each period wrap and a registered near-50% clk_out.
// Supports continuous (mode=0) and one-shot (mode=1) operation.
module prog_freq_divider #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 8192
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             start,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_active
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH:0]   ONE_X   = (WIDTH + 1)'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] n_cur;
    logic [WIDTH-1:0] n_next;
    logic [WIDTH:0]   half_next;
    logic             run_cycle;
    logic             wrap;

    // Divisors of 0 or 1 are meaningless; store them as 2
    assign load_val = (div_value < TWO) ? TWO : div_value;

    // State register with synchronous reset; reset discards any pending divisor
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            div_q        <= DIV_RST;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            clk_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            div_q        <= div_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            clk_out_q    <= clk_out_d;
        end
    end

    // Next-state: FSM transitions, counting, divisor hand-over at period boundaries
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        div_d        = div_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        tick_d       = 1'b0;
        clk_out_d    = clk_out_q;
        n_cur        = div_q;
        n_next       = div_q;
        half_next    = '0;
        run_cycle    = 1'b0;
        wrap         = 1'b0;

        if (div_load) begin
            pend_d       = load_val;
            pend_valid_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (enable && (!mode || start)) begin
                    state_d   = S_RUN;
                    run_cycle = 1'b1;
                    // Pending divisor takes effect on entry; the same cycle counts
                    if (pend_valid_q) begin
                        n_cur = pend_q;
                        div_d = pend_q;
                        if (!div_load) begin
                            pend_valid_d = 1'b0;
                        end
                    end
                end
            end
            S_RUN: begin
                run_cycle = enable;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        n_next = n_cur;
        if (run_cycle) begin
            if (count_q == n_cur - ONE) begin
                wrap    = 1'b1;
                count_d = '0;
                tick_d  = 1'b1;
                // A load coinciding with the wrap bypasses the pending register
                if (div_load) begin
                    n_next = load_val;
                end else if (pend_valid_q) begin
                    n_next = pend_q;
                end
                pend_valid_d = 1'b0;
                div_d        = n_next;
            end else begin
                count_d = count_q + ONE;
            end
            // Half period at WIDTH+1 bits so N = 2^WIDTH-1 does not overflow
            half_next = ({1'b0, n_next} + ONE_X) >> 1;
            clk_out_d = ({1'b0, count_d} < half_next);
            if (wrap && mode) begin
                clk_out_d = 1'b0;
                state_d   = S_IDLE;
            end
        end
    end

    assign tick       = tick_q;
    assign clk_out    = clk_out_q;
    assign busy       = (state_q == S_RUN);
    assign count      = count_q;
    assign div_active = div_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Randomized and directed bench for prog_freq_divider against a cycle-level
// integer reference model of the divider behaviour.
module tb_prog_freq_divider;

    localparam int WIDTH = 16;
    localparam int DEF   = 8192;

    logic             clk = 1'b0;
    logic             reset, enable, mode, start, div_load;
    logic [WIDTH-1:0] div_value;
    logic             tick, clk_out, busy;
    logic [WIDTH-1:0] count, div_active;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position in period, divisor, pending, running flag
    int m_pos, m_n, m_p;
    bit m_pv, m_run, m_tick, m_clk;

    prog_freq_divider #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .start     (start),
        .div_load  (div_load),
        .div_value (div_value),
        .tick      (tick),
        .clk_out   (clk_out),
        .busy      (busy),
        .count     (count),
        .div_active(div_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference behaviour for the inputs applied this cycle
    task automatic model_step(input bit r, input bit en, input bit md, input bit st,
                              input bit ld, input int dv);
        bit cnt;
        bit wr;
        int ldv;
        ldv    = (dv < 2) ? 2 : dv;
        m_tick = 1'b0;
        if (r) begin
            m_pos = 0; m_run = 1'b0; m_n = DEF; m_pv = 1'b0; m_clk = 1'b0;
            return;
        end
        cnt = 1'b0;
        wr  = 1'b0;
        if (!m_run) begin
            if (en && (!md || st)) begin
                m_run = 1'b1;
                cnt   = 1'b1;
                if (m_pv) begin
                    m_n  = m_p;
                    m_pv = 1'b0;
                end
            end
        end else begin
            cnt = en;
        end
        if (cnt) begin
            m_pos++;
            if (m_pos == m_n) begin
                wr     = 1'b1;
                m_pos  = 0;
                m_tick = 1'b1;
                if (ld)        m_n = ldv;
                else if (m_pv) m_n = m_p;
                m_pv = 1'b0;
            end
            m_clk = (m_pos < (m_n + 1) / 2);
            if (wr && md) begin
                m_clk = 1'b0;
                m_run = 1'b0;
            end
        end
        if (ld && !wr) begin
            m_p  = ldv;
            m_pv = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit en, input bit md, input bit st,
                        input bit ld, input logic [WIDTH-1:0] dv);
        reset     = r;
        enable    = en;
        mode      = md;
        start     = st;
        div_load  = ld;
        div_value = dv;
        model_step(r, en, md, st, ld, int'(dv));
        @(posedge clk);
        #1;
        chk("count",      32'(count),      32'(m_pos));
        chk("div_active", 32'(div_active), 32'(m_n));
        chk("tick",       32'(tick),       32'(m_tick));
        chk("clk_out",    32'(clk_out),    32'(m_clk));
        chk("busy",       32'(busy),       32'(m_run));
    endtask

    // Start a single shot; optionally stall enable for two cycles from index stall_at
    task automatic one_shot(input int stall_at, input int exp_len);
        int  len;
        int  ticks;
        bit  done;
        bit  en;
        len   = 0;
        ticks = 0;
        done  = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            en = !(stall_at >= 0 && i >= stall_at && i < stall_at + 2);
            // A second start while running must be ignored
            step(1'b0, en, 1'b1, (i < 2), 1'b0, '0);
            len++;
            ticks += int'(tick);
            if (!busy) done = 1'b1;
        end
        chk("shot_len",   32'(len),     32'(exp_len));
        chk("shot_ticks", 32'(ticks),   32'd1);
        chk("shot_clk0",  32'(clk_out), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk("shot_noqueue", 32'(busy), 32'd0);
    endtask

    initial begin
        bit               r, en, md, st, ld;
        logic [WIDTH-1:0] dv;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_div", 32'(div_active), 32'(DEF));
        chk("rst_cnt", 32'(count), 32'd0);

        // N=4 continuous
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("n4_first_clk", 32'(clk_out), 32'd1);
        chk("n4_first_cnt", 32'(count), 32'd1);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Load 6 mid-period
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd6);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Load 5 coincident with a wrap
        for (int i = 0; i < 10 && m_pos != m_n - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5);
        chk("wrap_bypass", 32'(div_active), 32'd5);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Clamp of 0 and 1
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("clamp0", 32'(div_active), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("clamp1", 32'(div_active), 32'd2);

        // Switch to one-shot: returns to IDLE at the next wrap
        for (int i = 0; i < 10 && m_run; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk("to_idle", 32'(busy), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3);
        one_shot(-1, 3);
        one_shot(1, 5);

        // Reset mid-period at count=2, N=6
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd9);
        chk("pre_rst_cnt", 32'(count), 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("midrst_div", 32'(div_active), 32'(DEF));
        chk("midrst_busy", 32'(busy), 32'd0);

        // Largest divisor: half period must not overflow
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("maxn_clk", 32'(clk_out), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Randomized segments
        md = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6);
        for (int seg = 0; seg < 15; seg++) begin
            md = 1'($urandom_range(0, 1));
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 49) == 0) md = ~md;
                r  = ($urandom_range(0, 499) == 0);
                en = ($urandom_range(0, 99) < 85);
                st = ($urandom_range(0, 99) < 15);
                ld = ($urandom_range(0, 99) < 6);
                dv = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(0, 40))
                                                  : 16'($urandom_range(0, 10));
                step(r, en, md, st, ld, dv);
                if (r) step(1'b0, 1'b0, md, 1'b0, 1'b1, 16'($urandom_range(0, 10)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_freq_divider.md
Name: prog_freq_divider

Overview:
Programmable, parametrised clock-enable/frequency divider that replaces fixed power-of-two toggle-chain dividers. It divides `clk` by any runtime-loadable integer N (2..2^WIDTH-1). It produces both a one-cycle `tick` strobe and a near-50% duty `clk_out`, and supports continuous and one-shot (single period) modes. It feeds timers, display multiplexers and debounce logic in the same design.

Parameters:
WIDTH, 16, bit width of counter and divisor.
DEFAULT_DIV, 8192, active divisor after reset; must be >= 2 and < 2^WIDTH.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  count enable; 0 freezes count and clk_out.
mode  input  1  0 = continuous, 1 = one-shot.
start  input  1  one-shot trigger, sampled only in mode 1 while IDLE and enable=1.
div_load  input  1  strobe; captures div_value into pending register.
div_value  input  WIDTH  requested divisor N.
tick  output  1  one-cycle pulse at each period wrap.
clk_out  output  1  divided square wave, registered.
busy  output  1  1 while FSM is in RUN.
count  output  WIDTH  current counter value.
div_active  output  WIDTH  divisor currently in use.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values: count=0, tick=0, clk_out=0, busy=0, div_active=DEFAULT_DIV, pending cleared, FSM=IDLE. Reset mid-period aborts immediately and discards any pending divisor.
- Divisor clamp: a loaded value of 0 or 1 is stored as 2.
- H = (N+1)>>1, where N = div_active. clk_out is high for H cycles and low for N-H cycles.
- FSM states: IDLE and RUN.
  - IDLE→RUN:
    - mode=0: on any cycle with enable=1.
    - mode=1: on start=1 with enable=1.
  - RUN→IDLE: only at a wrap while mode=1.
- Entering RUN:
  - The pending divisor, if valid, is applied immediately.
  - The first counting cycle takes place in the same cycle as the transition, so count goes 0→1.
- Counting, each RUN cycle with enable=1:
  - If count==N-1: count←0, tick←1, apply pending divisor if valid (this becomes the new N).
  - Otherwise: count←count+1, tick←0.
  - clk_out←(count_next < H_next).
- enable=0: count, clk_out and FSM hold; tick←0. busy holds its value.
- Wrap in mode 1: count←0, tick←1, clk_out←0, FSM→IDLE, busy←0.
- Mode sampling: mode is sampled only at wraps and in IDLE. A change mid-period takes effect at the next wrap.
- div_load:
  - Sets pending←clamp(div_value) and pending_valid←1.
  - A later div_load before the apply point overwrites pending.
  - The divisor is never changed mid-period, so no runt pulses.
  - div_load in the same cycle as a wrap: div_value bypasses pending and becomes div_active at that wrap.
- start while RUN, or start with enable=0: ignored, not queued.
- tick latency: tick is asserted in the cycle after the register update that produces count=0. In steady state the first tick follows N enabled cycles after IDLE→RUN.
- Width rules:
  - All comparisons are unsigned WIDTH-bit.
  - count never exceeds N-1.
  - (N+1)>>1 is computed at WIDTH+1 bits to avoid overflow at N=2^WIDTH-1.

Test Plan:
- Reset, then load N=4, mode=0, enable=1 held → tick every 4 cycles. Starting from the cycle after enable is first sampled, clk_out=1,0,0,1,1,0,0,1… (2 high/2 low); count cycles 1,2,3,0.
- Odd divisor N=5, mode=0 → clk_out 3 cycles high, 2 low; tick period 5; div_active=5.
- Load N=6 mid-period while running at N=4 → current period completes at 4; the next periods are 6 with no runt. Repeat with div_load coincident with wrap → the new N applies at that wrap.
- Load N=0 and N=1 → div_active reads 2; tick every 2 cycles; clk_out alternates 1,0.
- One-shot, N=3:
  - start pulse → busy=1 for 3 cycles, exactly one tick, then IDLE with clk_out=0.
  - Second start during RUN → ignored.
  - enable=0 for 2 cycles mid-shot → period stretches by 2.
- Reset asserted mid-period (count=2, N=6) → next cycle count=0, tick=0, clk_out=0, busy=0, div_active=DEFAULT_DIV (8192), pending discarded.
